sdram_burst_reader: RTL

Parametrised SDRAM read engine that issues PRECHARGE-ALL / ACTIVE / READ sequences for one burst per trigger. It walks a frame-sized address space (bank, row, column) and returns burst data with a valid strobe. It sits between the frame consumer (display/FIFO side) and the SDRAM command arbiter, and requests the bus through a req/grant handshake. Relative to the fixed-timing version it adds configurable geometry, burst length, CAS latency, tRP/tRCD, bank selection, trigger queuing, deferred frame clear and a last-beat marker.

---
 rtl/sdram_burst_reader.sv | 218 +++++++++++++++++++++
 1 files changed

// File: rtl/sdram_burst_reader.sv
// One-burst-per-trigger SDRAM read engine: PRE-all / ACT / RD sequencing over a frame
// of rows and columns, with registered command, address and read-data outputs.
//
// state      | meaning
// IDLE       | waiting for a trigger (live or pending)
// REQ        | rd_req raised, waiting for the arbiter grant
// PRE        | precharge-all command
// WAIT_RP    | NOP spacing before ACT
// ACT        | activate current row
// WAIT_RCD   | NOP spacing before RD
// RD         | read command at current column
// WAIT_DATA  | CAS latency plus burst beats
// DONE       | burst finished, address advance or deferred clear
module sdram_burst_reader #(
  parameter int DQ_W      = 16,
  parameter int ROW_W     = 13,
  parameter int COL_W     = 10,
  parameter int BANK_W    = 2,
  parameter int BURST_LEN = 8,
  parameter int CAS_LAT   = 2,
  parameter int T_RP      = 2,
  parameter int T_RCD     = 2,
  parameter int COL_END   = 632,
  parameter int ROW_END   = 479,
  parameter int BANK_SEL  = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rd_trig,
  output logic              rd_req,
  input  logic              rd_en,
  input  logic              frame_clr,
  output logic [3:0]        rd_cmd,
  output logic [ROW_W-1:0]  rd_addr,
  output logic [BANK_W-1:0] rd_bank,
  input  logic [DQ_W-1:0]   sdram_dq,
  output logic [DQ_W-1:0]   rd_dq,
  output logic              rd_data_valid,
  output logic              rd_last,
  output logic              busy,
  output logic              flag_rd_end,
  output logic              frame_end
);

  localparam logic [3:0] CMD_NOP = 4'b0111;
  localparam logic [3:0] CMD_PRE = 4'b0010;
  localparam logic [3:0] CMD_ACT = 4'b0011;
  localparam logic [3:0] CMD_RD  = 4'b0101;

  localparam int DATA_CYC = CAS_LAT + BURST_LEN;
  localparam int TMR_MAX  = (DATA_CYC > T_RP) ? ((DATA_CYC > T_RCD) ? DATA_CYC : T_RCD)
                                              : ((T_RP > T_RCD) ? T_RP : T_RCD);
  localparam int TMR_W    = $clog2(TMR_MAX + 1);

  typedef enum logic [3:0] {
    S_IDLE, S_REQ, S_PRE, S_WAIT_RP, S_ACT, S_WAIT_RCD, S_RD, S_WAIT_DATA, S_DONE
  } state_t;

  state_t            state, state_d;
  logic [TMR_W-1:0]  tmr, tmr_d;
  logic [ROW_W-1:0]  row, row_d;
  logic [COL_W-1:0]  col, col_d;
  logic              pend_trig, pend_trig_d;
  logic              pend_clr, pend_clr_d;
  logic              valid_d, last_d, frame_end_d;
  logic [3:0]        cmd_d;
  logic [ROW_W-1:0]  addr_d;

  always_comb begin
    state_d     = state;
    tmr_d       = tmr;
    row_d       = row;
    col_d       = col;
    pend_trig_d = pend_trig;
    pend_clr_d  = pend_clr;
    valid_d     = 1'b0;
    last_d      = 1'b0;

    if (rd_trig && state != S_IDLE) pend_trig_d = 1'b1;
    if (frame_clr && state != S_IDLE && state != S_REQ) pend_clr_d = 1'b1;

    case (state)
      S_IDLE: begin
        if (rd_trig || pend_trig) begin
          state_d     = S_REQ;
          pend_trig_d = 1'b0;
        end
        if (frame_clr) begin
          row_d = '0;
          col_d = '0;
        end
      end
      S_REQ: begin
        if (rd_en) state_d = S_PRE;
        if (frame_clr) begin
          row_d = '0;
          col_d = '0;
        end
      end
      S_PRE: begin
        if (T_RP > 1) begin
          state_d = S_WAIT_RP;
          tmr_d   = TMR_W'(T_RP - 1);
        end else begin
          state_d = S_ACT;
        end
      end
      S_WAIT_RP: begin
        if (tmr == TMR_W'(1)) state_d = S_ACT;
        else                  tmr_d   = tmr - TMR_W'(1);
      end
      S_ACT: begin
        if (T_RCD > 1) begin
          state_d = S_WAIT_RCD;
          tmr_d   = TMR_W'(T_RCD - 1);
        end else begin
          state_d = S_RD;
        end
      end
      S_WAIT_RCD: begin
        if (tmr == TMR_W'(1)) state_d = S_RD;
        else                  tmr_d   = tmr - TMR_W'(1);
      end
      S_RD: begin
        state_d = S_WAIT_DATA;
        tmr_d   = TMR_W'(DATA_CYC);
      end
      S_WAIT_DATA: begin
        // tmr counts cycles left until DONE; beats land in the last BURST_LEN of them
        valid_d = (tmr >= TMR_W'(2)) && (tmr <= TMR_W'(BURST_LEN + 1));
        last_d  = (tmr == TMR_W'(2));
        if (tmr == TMR_W'(1)) state_d = S_DONE;
        else                  tmr_d   = tmr - TMR_W'(1);
      end
      S_DONE: begin
        state_d = S_IDLE;
        if (pend_clr || frame_clr) begin
          row_d      = '0;
          col_d      = '0;
          pend_clr_d = 1'b0;
        end else if (col == COL_W'(COL_END)) begin
          col_d = '0;
          row_d = (row == ROW_W'(ROW_END)) ? '0 : row + ROW_W'(1);
        end else begin
          col_d = col + COL_W'(BURST_LEN);
        end
      end
      default: state_d = S_IDLE;
    endcase

    frame_end_d = (state_d == S_DONE) && (row == ROW_W'(ROW_END)) && (col == COL_W'(COL_END));

    cmd_d  = CMD_NOP;
    addr_d = row_d;
    case (state_d)
      S_PRE: begin
        cmd_d      = CMD_PRE;
        addr_d     = '0;
        addr_d[10] = 1'b1;
      end
      S_ACT: begin
        cmd_d  = CMD_ACT;
        addr_d = row_d;
      end
      S_RD: begin
        cmd_d      = CMD_RD;
        addr_d     = ROW_W'(col_d);
        addr_d[10] = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      tmr       <= '0;
      row       <= '0;
      col       <= '0;
      pend_trig <= 1'b0;
      pend_clr  <= 1'b0;
    end else begin
      state     <= state_d;
      tmr       <= tmr_d;
      row       <= row_d;
      col       <= col_d;
      pend_trig <= pend_trig_d;
      pend_clr  <= pend_clr_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_req        <= 1'b0;
      rd_cmd        <= CMD_NOP;
      rd_addr       <= '0;
      rd_bank       <= BANK_W'(BANK_SEL);
      rd_dq         <= '0;
      rd_data_valid <= 1'b0;
      rd_last       <= 1'b0;
      busy          <= 1'b0;
      flag_rd_end   <= 1'b0;
      frame_end     <= 1'b0;
    end else begin
      rd_req        <= (state_d == S_REQ);
      rd_cmd        <= cmd_d;
      rd_addr       <= addr_d;
      rd_bank       <= BANK_W'(BANK_SEL);
      rd_dq         <= sdram_dq;
      rd_data_valid <= valid_d;
      rd_last       <= last_d;
      busy          <= (state_d != S_IDLE) && (state_d != S_REQ);
      flag_rd_end   <= (state_d == S_DONE);
      frame_end     <= frame_end_d;
    end
  end

endmodule
